mem_access_unit: RTL and testbench

//  Sequential load/store unit between the pipeline and byte-banked block RAM plus an MMIO port.

---
 rtl/mem_access_unit.sv | 177 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store unit: byte-banked block RAM with misaligned wrap-around access,
// plus an MMIO port with wait states. One access in flight at a time.
module mem_access_unit #(
    parameter int LANES               = 4,
    parameter int BLOCK_ADDR_WIDTH    = 10,
    parameter int MMIO_ADDR_START_BIT = 31
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               req_valid,
    output logic                               req_ready,
    input  logic                               req_we,
    input  logic [$clog2(LANES)-1:0]           req_size,
    input  logic                               req_sext,
    input  logic [31:0]                        req_addr,
    input  logic [8*LANES-1:0]                 req_wdata,
    output logic [LANES-1:0]                   bank_we,
    output logic [LANES*BLOCK_ADDR_WIDTH-1:0]  bank_addr,
    output logic [8*LANES-1:0]                 bank_wdata,
    input  logic [8*LANES-1:0]                 bank_rdata,
    output logic                               mmio_valid,
    input  logic                               mmio_ready,
    output logic                               mmio_we,
    output logic [31:0]                        mmio_addr,
    output logic [LANES-1:0]                   mmio_wstrb,
    output logic [8*LANES-1:0]                 mmio_wdata,
    input  logic [8*LANES-1:0]                 mmio_rdata,
    output logic                               resp_valid,
    input  logic                               resp_ready,
    output logic [8*LANES-1:0]                 resp_data,
    output logic                               resp_err
);
    localparam int DW  = 8 * LANES;
    localparam int OW  = $clog2(LANES);
    localparam int BAW = BLOCK_ADDR_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_RD, S_MIO, S_RESP} state_t;

    state_t state, state_nx;

    logic [OW-1:0]   off_q;
    logic [OW-1:0]   size_q;
    logic            sext_q;
    logic            we_q;
    logic [31:0]     mmio_addr_q;
    logic [LANES-1:0] wstrb_q;
    logic [DW-1:0]   wdata_q;
    logic [DW-1:0]   resp_data_q;
    logic            resp_err_q;

    logic            accept;
    logic [OW-1:0]   req_off;
    logic            is_mmio;
    logic            misaligned;
    logic [BAW-1:0]  wa, na;

    function automatic logic [DW-1:0] rotl_bytes(input logic [DW-1:0] d, input logic [OW-1:0] sh);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < LANES; i++)
            r[8*i +: 8] = d[8*((i - int'(sh)) & (LANES-1)) +: 8];
        return r;
    endfunction

    function automatic logic [DW-1:0] rotr_bytes(input logic [DW-1:0] d, input logic [OW-1:0] sh);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < LANES; i++)
            r[8*i +: 8] = d[8*((i + int'(sh)) & (LANES-1)) +: 8];
        return r;
    endfunction

    function automatic logic [LANES-1:0] strb_of(input logic [OW-1:0] size, input logic [OW-1:0] off);
        logic [LANES-1:0] s;
        s = '0;
        for (int k = 0; k < LANES; k++)
            if (k < (1 << size)) s[(k + int'(off)) & (LANES-1)] = 1'b1;
        return s;
    endfunction

    // Align, truncate to 2**size bytes, then zero- or sign-fill the upper bytes.
    function automatic logic [DW-1:0] load_fmt(input logic [DW-1:0] d, input logic [OW-1:0] off,
                                               input logic [OW-1:0] size, input logic sext);
        logic [DW-1:0] rot, r;
        int            nb;
        logic          fill;
        rot  = rotr_bytes(d, off);
        nb   = 1 << size;
        fill = sext & rot[8*nb-1];
        r    = '0;
        for (int k = 0; k < LANES; k++)
            r[8*k +: 8] = (k < nb) ? rot[8*k +: 8] : {8{fill}};
        return r;
    endfunction

    assign accept     = req_valid & (state == S_IDLE);
    assign req_off    = req_addr[OW-1:0];
    assign is_mmio    = req_addr[MMIO_ADDR_START_BIT];
    assign misaligned = (int'(req_off) & ((1 << req_size) - 1)) != 0;
    assign wa         = req_addr[OW +: BAW];
    assign na         = wa + BAW'(1);

    // Banks below the offset hold the bytes that spilled into the next word.
    always_comb begin
        bank_we    = '0;
        bank_addr  = '0;
        bank_wdata = '0;
        if (accept) begin
            for (int i = 0; i < LANES; i++)
                bank_addr[i*BAW +: BAW] = (i < int'(req_off)) ? na : wa;
            bank_wdata = rotl_bytes(req_wdata, req_off);
            if (req_we && !is_mmio) bank_we = strb_of(req_size, req_off);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (accept) begin
                if (is_mmio) state_nx = misaligned ? S_RESP : S_MIO;
                else         state_nx = req_we ? S_RESP : S_RD;
            end
            S_RD:   state_nx = S_RESP;
            S_MIO:  if (mmio_ready) state_nx = S_RESP;
            S_RESP: if (resp_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            off_q       <= '0;
            size_q      <= '0;
            sext_q      <= 1'b0;
            we_q        <= 1'b0;
            mmio_addr_q <= '0;
            wstrb_q     <= '0;
            wdata_q     <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    off_q       <= req_off;
                    size_q      <= req_size;
                    sext_q      <= req_sext;
                    we_q        <= req_we;
                    resp_data_q <= '0;
                    resp_err_q  <= is_mmio & misaligned;
                    mmio_addr_q <= {req_addr[31:OW], {OW{1'b0}}};
                    wstrb_q     <= strb_of(req_size, req_off);
                    wdata_q     <= rotl_bytes(req_wdata, req_off);
                end
                S_RD:  resp_data_q <= load_fmt(bank_rdata, off_q, size_q, sext_q);
                S_MIO: if (mmio_ready && !we_q)
                    resp_data_q <= load_fmt(mmio_rdata, off_q, size_q, sext_q);
                default: ;
            endcase
        end
    end

    assign req_ready  = (state == S_IDLE);
    assign mmio_valid = (state == S_MIO);
    assign mmio_we    = mmio_valid & we_q;
    assign mmio_addr  = mmio_valid ? mmio_addr_q : '0;
    assign mmio_wstrb = mmio_valid ? wstrb_q : '0;
    assign mmio_wdata = mmio_valid ? wdata_q : '0;
    assign resp_valid = (state == S_RESP);
    assign resp_data  = resp_valid ? resp_data_q : '0;
    assign resp_err   = resp_valid & resp_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a 4-lane banked RAM model and a hand-driven MMIO port.
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_sext;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  bank_we;
    logic [39:0] bank_addr;
    logic [31:0] bank_wdata, bank_rdata;
    logic        mmio_valid, mmio_ready, mmio_we;
    logic [31:0] mmio_addr, mmio_wdata, mmio_rdata;
    logic [3:0]  mmio_wstrb;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_data;

    int checks = 0;
    int errors = 0;
    int mmio_cycles = 0;

    logic [7:0] mem [4][1024];

    logic [3:0]  acc_we;
    logic [39:0] acc_addr;
    logic [31:0] acc_wdata;
    logic        acc_ok;

    mem_access_unit dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_sext(req_sext), .req_addr(req_addr), .req_wdata(req_wdata),
        .bank_we(bank_we), .bank_addr(bank_addr), .bank_wdata(bank_wdata), .bank_rdata(bank_rdata),
        .mmio_valid(mmio_valid), .mmio_ready(mmio_ready), .mmio_we(mmio_we),
        .mmio_addr(mmio_addr), .mmio_wstrb(mmio_wstrb), .mmio_wdata(mmio_wdata),
        .mmio_rdata(mmio_rdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    // Banked block RAM: one-cycle read latency, byte-wide write per bank.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (bank_we[i]) mem[i][bank_addr[i*10 +: 10]] <= bank_wdata[8*i +: 8];
            bank_rdata[8*i +: 8] <= mem[i][bank_addr[i*10 +: 10]];
        end
    end

    always @(negedge clk) if (mmio_valid) mmio_cycles++;

    task automatic do_req(input logic we, input logic [1:0] size, input logic sext,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output int lat, output logic [31:0] data, output logic err);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size; req_sext = sext;
        req_addr = addr; req_wdata = wd;
        #1;
        acc_ok = req_ready; acc_we = bank_we; acc_addr = bank_addr; acc_wdata = bank_wdata;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        data = resp_data;
        err  = resp_err;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({req_ready, resp_valid, mmio_valid, bank_we, resp_err, resp_data} !== {1'b1, 1'b0, 1'b0, 4'b0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b rv=%b mv=%b we=%b err=%b data=%h, required ready=1 rest 0",
                     req_ready, resp_valid, mmio_valid, bank_we, resp_err, resp_data);
        end
    endtask

    task automatic test_aligned_word();
        int lat; logic [31:0] d; logic e;
        do_req(1'b1, 2'd2, 1'b0, 32'h100, 32'h11223344, lat, d, e);
        checks++;
        if (acc_we !== 4'b1111 || acc_addr !== {4{10'h040}}) begin
            errors++;
            $display("FAIL store_0x100_banks: we=%b addr=%h, required we=1111 addr=%h", acc_we, acc_addr, {4{10'h040}});
        end
        checks++;
        if (lat !== 1 || d !== 32'h0 || e !== 1'b0) begin
            errors++;
            $display("FAIL store_0x100_resp: lat=%0d data=%h err=%b, required lat=1 data=0 err=0", lat, d, e);
        end
        do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, lat, d, e);
        checks++;
        if (acc_we !== 4'b0000) begin
            errors++;
            $display("FAIL load_0x100_we: we=%b, required 0000", acc_we);
        end
        checks++;
        if (lat !== 2 || d !== 32'h11223344) begin
            errors++;
            $display("FAIL load_0x100: lat=%0d data=%h, required lat=2 data=11223344", lat, d);
        end
    endtask

    task automatic test_misaligned_ram();
        int lat; logic [31:0] d; logic e;
        do_req(1'b1, 2'd2, 1'b0, 32'h103, 32'hAABBCCDD, lat, d, e);
        checks++;
        if (acc_we !== 4'b1111 || acc_wdata !== 32'hDDAABBCC) begin
            errors++;
            $display("FAIL store_0x103_we_data: we=%b wdata=%h, required we=1111 wdata=ddaabbcc", acc_we, acc_wdata);
        end
        checks++;
        if (acc_addr !== {10'h040, 10'h041, 10'h041, 10'h041}) begin
            errors++;
            $display("FAIL store_0x103_addr: addr=%h, required bank3=040 bank0-2=041", acc_addr);
        end
        do_req(1'b0, 2'd2, 1'b0, 32'h103, 32'h0, lat, d, e);
        checks++;
        if (lat !== 2 || d !== 32'hAABBCCDD) begin
            errors++;
            $display("FAIL load_0x103: lat=%0d data=%h, required lat=2 data=aabbccdd", lat, d);
        end
    endtask

    task automatic test_byte_sext();
        int lat; logic [31:0] d; logic e;
        do_req(1'b1, 2'd0, 1'b0, 32'h205, 32'h00000080, lat, d, e);
        checks++;
        if (acc_we !== 4'b0010 || acc_wdata[15:8] !== 8'h80) begin
            errors++;
            $display("FAIL store_byte_0x205: we=%b wdata=%h, required we=0010 byte1=80", acc_we, acc_wdata);
        end
        do_req(1'b0, 2'd0, 1'b1, 32'h205, 32'h0, lat, d, e);
        checks++;
        if (d !== 32'hFFFFFF80) begin
            errors++;
            $display("FAIL load_byte_sext: data=%h, required ffffff80", d);
        end
        do_req(1'b0, 2'd0, 1'b0, 32'h205, 32'h0, lat, d, e);
        checks++;
        if (d !== 32'h00000080) begin
            errors++;
            $display("FAIL load_byte_zext: data=%h, required 00000080", d);
        end
    endtask

    task automatic test_wrap();
        int lat; logic [31:0] d; logic e;
        do_req(1'b1, 2'd1, 1'b0, 32'hFFF, 32'h0000BEEF, lat, d, e);
        checks++;
        if (acc_we !== 4'b1001 || acc_addr[39:30] !== 10'h3FF || acc_addr[9:0] !== 10'h000) begin
            errors++;
            $display("FAIL store_half_wrap: we=%b addr=%h, required we=1001 bank3=3ff bank0=000", acc_we, acc_addr);
        end
        do_req(1'b0, 2'd1, 1'b0, 32'hFFF, 32'h0, lat, d, e);
        checks++;
        if (d !== 32'h0000BEEF) begin
            errors++;
            $display("FAIL load_half_wrap: data=%h, required 0000beef", d);
        end
    endtask

    task automatic test_mmio_wait();
        logic [31:0] held;
        @(negedge clk);
        resp_ready = 1'b0;
        mmio_cycles = 0;
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_sext = 1'b0;
        req_addr = 32'h80000010; req_wdata = 32'h0;
        #1;
        checks++;
        if (bank_we !== 4'b0000) begin
            errors++;
            $display("FAIL mmio_bank_we: we=%b, required 0000", bank_we);
        end
        @(negedge clk);
        req_valid = 1'b0;
        for (int w = 0; w < 3; w++) begin
            checks++;
            if (mmio_valid !== 1'b1 || mmio_addr !== 32'h80000010 || mmio_we !== 1'b0 || mmio_wstrb !== 4'b1111) begin
                errors++;
                $display("FAIL mmio_hold_%0d: valid=%b addr=%h we=%b strb=%b, required 1 80000010 0 1111",
                         w, mmio_valid, mmio_addr, mmio_we, mmio_wstrb);
            end
            @(negedge clk);
        end
        mmio_ready = 1'b1; mmio_rdata = 32'hDEADBEEF;
        @(negedge clk);
        mmio_ready = 1'b0; mmio_rdata = 32'h0;
        checks++;
        if (mmio_cycles !== 4) begin
            errors++;
            $display("FAIL mmio_valid_cycles: got %0d, required 4", mmio_cycles);
        end
        held = resp_data;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== 32'hDEADBEEF || held !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL mmio_resp_hold: valid=%b data=%h first=%h, required 1 deadbeef", resp_valid, resp_data, held);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL mmio_resp_consumed: rv=%b ready=%b, required 0 1", resp_valid, req_ready);
        end
    endtask

    task automatic test_mmio_store();
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_sext = 1'b0;
        req_addr = 32'h80000006; req_wdata = 32'h0000005A;
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (mmio_valid !== 1'b1 || mmio_we !== 1'b1 || mmio_addr !== 32'h80000004 ||
            mmio_wstrb !== 4'b0100 || mmio_wdata !== 32'h005A0000) begin
            errors++;
            $display("FAIL mmio_store: v=%b we=%b addr=%h strb=%b wdata=%h, required 1 1 80000004 0100 005a0000",
                     mmio_valid, mmio_we, mmio_addr, mmio_wstrb, mmio_wdata);
        end
        mmio_ready = 1'b1;
        @(negedge clk);
        mmio_ready = 1'b0;
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== 32'h0 || resp_err !== 1'b0) begin
            errors++;
            $display("FAIL mmio_store_resp: rv=%b data=%h err=%b, required 1 0 0", resp_valid, resp_data, resp_err);
        end
    endtask

    task automatic test_mmio_misaligned();
        int lat; logic [31:0] d; logic e;
        mmio_cycles = 0;
        do_req(1'b0, 2'd1, 1'b0, 32'h80000003, 32'h0, lat, d, e);
        checks++;
        if (lat !== 1 || e !== 1'b1 || mmio_cycles !== 0) begin
            errors++;
            $display("FAIL mmio_misaligned: lat=%0d err=%b mmio_cycles=%0d, required 1 1 0", lat, e, mmio_cycles);
        end
    endtask

    task automatic test_reset_mid_mio();
        int lat; logic [31:0] d; logic e;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_sext = 1'b0;
        req_addr = 32'h80000020; req_wdata = 32'h0;
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (mmio_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_mio_enter: mmio_valid=%b, required 1", mmio_valid);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (mmio_valid !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_mio_reset: mv=%b rv=%b ready=%b, required 0 0 1", mmio_valid, resp_valid, req_ready);
        end
        do_req(1'b1, 2'd2, 1'b0, 32'h300, 32'hCAFEF00D, lat, d, e);
        do_req(1'b0, 2'd2, 1'b0, 32'h300, 32'h0, lat, d, e);
        checks++;
        if (acc_ok !== 1'b1 || lat !== 2 || d !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL after_reset_load: ready=%b lat=%0d data=%h, required 1 2 cafef00d", acc_ok, lat, d);
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_sext = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        mmio_ready = 1'b0; mmio_rdata = 32'h0; resp_ready = 1'b1;
        for (int b = 0; b < 4; b++)
            for (int a = 0; a < 1024; a++) mem[b][a] = 8'h00;
        test_reset();
        test_aligned_word();
        test_misaligned_ram();
        test_byte_sext();
        test_wrap();
        test_mmio_wait();
        test_mmio_store();
        test_mmio_misaligned();
        test_reset_mid_mio();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
